// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first,
// with a start/busy/done handshake and a sticky invalid-digit flag.
module bcd_serial_addsub #(
    parameter int unsigned N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  sub_i,
    input  logic [4*N_DIGITS-1:0] a_i,
    input  logic [4*N_DIGITS-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*N_DIGITS-1:0] sum_o,
    output logic                  cout_o,
    output logic                  err_o
);

    localparam int unsigned W    = 4 * N_DIGITS;
    localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    a_q, b_q, shadow_q, sum_q;
    logic            sub_q, carry_q, err_acc_q;
    logic [IdxW-1:0] idx_q;
    logic            busy_q, done_q, cout_q, err_q;

    logic [3:0]      a_dig, b_dig, b_cmp, digit;
    logic [4:0]      dsum;
    logic            carry_d, err_d;
    logic [W-1:0]    shadow_d;

    // Digit step; subtraction uses nine's complement of b plus initial carry of 1.
    always_comb begin
        a_dig    = a_q[{idx_q, 2'b00} +: 4];
        b_dig    = b_q[{idx_q, 2'b00} +: 4];
        b_cmp    = sub_q ? (4'd9 - b_dig) : b_dig;
        dsum     = {1'b0, a_dig} + {1'b0, b_cmp} + {4'd0, carry_q};
        digit    = dsum[3:0];
        carry_d  = 1'b0;
        if (dsum > 5'd9) begin
            digit   = dsum[3:0] + 4'd6;
            carry_d = 1'b1;
        end
        err_d    = err_acc_q | (a_dig > 4'd9) | (b_dig > 4'd9);
        shadow_d = shadow_q;
        shadow_d[{idx_q, 2'b00} +: 4] = digit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            shadow_q  <= '0;
            sum_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            err_acc_q <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q       <= a_i;
                        b_q       <= b_i;
                        sub_q     <= sub_i;
                        carry_q   <= sub_i;
                        idx_q     <= '0;
                        err_acc_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    shadow_q  <= shadow_d;
                    carry_q   <= carry_d;
                    err_acc_q <= err_d;
                    if (idx_q == LastIdx) begin
                        // Publish the whole result at once so sum_o never shows a partial value.
                        idx_q   <= '0;
                        sum_q   <= shadow_d;
                        cout_q  <= carry_d;
                        err_q   <= err_d;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub (N_DIGITS=4): directed table, handshake/reset
// sequences and random operations checked against an integer-arithmetic model.
module tb_bcd_serial_addsub;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        sub_i = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        busy_o, done_o, cout_o, err_o;
    logic [15:0] sum_o;

    bcd_serial_addsub #(.N_DIGITS(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start_i),
        .sub_i  (sub_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .sum_o  (sum_o),
        .cout_o (cout_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_hold = '0;
    bit          hold_known = 1'b1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        err;
        bit          sdef;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int unsigned bcd_val(input logic [15:0] v);
        int unsigned r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int unsigned x);
        logic [15:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit all_valid(input logic [15:0] v);
        for (int i = 0; i < N; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // One operation: checks acceptance, sum stability while busy, latency and results.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] es, input logic ec, input logic ee,
                         input bit sdef, input bit poke);
        int lat;
        int extra_done;
        @(negedge clk);
        a_i = a; b_i = b; sub_i = s; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        a_i = 16'($urandom); b_i = 16'($urandom); sub_i = ~s;
        chk("busy_on_accept", {31'd0, busy_o}, 32'd1);
        for (lat = 1; lat <= 20; lat++) begin
            if (lat > 1) begin @(posedge clk); #1; end
            start_i = poke && (lat == 2);
            if (poke && lat == 2) begin a_i = 16'h1111; b_i = 16'h2222; end
            if (done_o) break;
            if (hold_known) chk("sum_hold_busy", {16'd0, sum_o}, {16'd0, exp_hold});
        end
        start_i = 1'b0;
        chk("done_seen", {31'd0, done_o}, 32'd1);
        if (done_o) begin
            chk("latency", lat, N + 1);
            chk("busy_at_done", {31'd0, busy_o}, 32'd1);
            chk("err", {31'd0, err_o}, {31'd0, ee});
            if (sdef) begin
                chk("sum", {16'd0, sum_o}, {16'd0, es});
                chk("cout", {31'd0, cout_o}, {31'd0, ec});
            end
        end
        @(posedge clk); #1;
        chk("done_pulse_end", {31'd0, done_o}, 32'd0);
        chk("busy_end", {31'd0, busy_o}, 32'd0);
        if (sdef) chk("sum_hold_idle", {16'd0, sum_o}, {16'd0, es});
        if (poke) begin
            extra_done = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                if (done_o || busy_o) extra_done++;
            end
            chk("ignored_start", extra_done, 0);
        end
        hold_known = sdef;
        exp_hold = es;
    endtask

    task automatic model_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        int unsigned va, vb, r;
        logic c;
        va = bcd_val(a);
        vb = bcd_val(b);
        if (s) begin
            c = (va >= vb);
            r = (va + 10000 - vb) % 10000;
        end else begin
            r = va + vb;
            c = (r >= 10000);
            r = r % 10000;
        end
        if (all_valid(a) && all_valid(b))
            do_op(a, b, s, to_bcd(r), c, 1'b0, 1'b1, 1'b0);
        else
            do_op(a, b, s, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    function automatic logic [15:0] rand_bcd(input bit allow_bad);
        logic [15:0] r;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && ($urandom_range(0, 7) == 0))
            r[$urandom_range(0, N - 1)*4 +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        int dcyc[$];
        tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'h0123, 16'h0456, 1'b1, 16'h9667, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1};

        #2;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_sum", {16'd0, sum_o}, 32'd0);
        chk("rst_cout", {31'd0, cout_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        foreach (tbl[i])
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sum, tbl[i].cout, tbl[i].err,
                  tbl[i].sdef, 1'b0);

        // start pulsed mid-RUN with other operands must be ignored
        do_op(16'h0250, 16'h0175, 1'b0, 16'h0425, 1'b0, 1'b0, 1'b1, 1'b1);

        // start held high: one operation every N+2 cycles
        @(negedge clk);
        a_i = 16'h0888; b_i = 16'h0222; sub_i = 1'b0; start_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done_o) dcyc.push_back(c);
        end
        start_i = 1'b0;
        chk("held_done_count", dcyc.size(), 3);
        if (dcyc.size() >= 3) begin
            chk("held_period_1", dcyc[1] - dcyc[0], N + 2);
            chk("held_period_2", dcyc[2] - dcyc[1], N + 2);
        end
        chk("held_sum", {16'd0, sum_o}, 32'h1110);
        repeat (10) @(posedge clk);
        #1;
        chk("held_drained", {31'd0, busy_o}, 32'd0);
        exp_hold = 16'h1110;
        hold_known = 1'b1;

        // reset during the second RUN cycle
        do_op(16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        a_i = 16'h1234; b_i = 16'h5678; sub_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_done", {31'd0, done_o}, 32'd0);
        chk("midrst_sum", {16'd0, sum_o}, 32'd0);
        chk("midrst_cout", {31'd0, cout_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) dn++;
        end
        chk("midrst_no_done", dn, 0);
        exp_hold = 16'h0000;
        hold_known = 1'b1;
        do_op(16'h0047, 16'h0958, 1'b0, 16'h1005, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 40; r++)
            model_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
